// File: rtl/fpmul_arb_pkg.sv
// fpmul_arb_pkg: shared widths, tag-width helper and FSM state type for fp_mul_arbiter
package fpmul_arb_pkg;
    localparam int FP_W   = 32;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;

    typedef enum logic {RUN, DRAIN} state_t;

    function automatic int clog2(input int n);
        for (int r = 0; r < 32; r++)
            if ((1 << r) >= n) return r;
        return 32;
    endfunction

    function automatic int tag_w(input int n);
        return (n < 2) ? 1 : clog2(n);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first active request at or after ptr
module rr_arbiter
    import fpmul_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TW   = tag_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [TW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [TW-1:0]   idx
);
    int   c;
    logic found;

    // scan ptr, ptr+1, ... with wrap; the first hit wins
    always_comb begin
        grant = '0;
        idx   = '0;
        c     = 0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            c = (int'(ptr) + i) % NREQ;
            if (en && req[c] && !found) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = TW'(c);
            end
        end
    end
endmodule

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin share of one FP multiplier; grant counters built when FPMUL_ARB_STATS_EN is defined
module fp_mul_arbiter
    import fpmul_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*FP_W-1:0] req_a,
    input  logic [NREQ*FP_W-1:0] req_b,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [FP_W-1:0]      rsp_data,
    input  logic [NREQ-1:0]      rsp_ready,
    input  logic                 drain_req,
    output logic                 idle,
    output logic [FP_W-1:0]      mul_a,
    output logic [FP_W-1:0]      mul_b,
    input  logic [FP_W-1:0]      mul_p,
    output logic [NREQ*16-1:0]   stat_grants
);
    localparam int TW = tag_w(NREQ);
    localparam int NS = LAT - 1;

    state_t          state, state_nx;
    logic [FP_W-1:0] s0_a, s0_b;
    logic [TW-1:0]   s0_tag;
    logic            s0_v;
    logic [FP_W-1:0] st_p   [NS];
    logic [TW-1:0]   st_tag [NS];
    logic [NS-1:0]   st_v;
    logic [TW-1:0]   ptr, gidx;
    logic [NREQ-1:0] grant;
    logic            adv, run_en, accept, any_v;

    assign adv       = !st_v[NS-1] || rsp_ready[st_tag[NS-1]];
    assign run_en    = adv && state == RUN && !drain_req;
    assign accept    = |grant;
    assign any_v     = s0_v || |st_v;
    assign idle      = !any_v;
    assign req_ready = grant;
    assign rsp_valid = st_v[NS-1] ? NREQ'(1) << st_tag[NS-1] : '0;
    assign rsp_data  = st_p[NS-1];
    assign mul_a     = s0_a;
    assign mul_b     = s0_b;

    rr_arbiter #(.NREQ(NREQ), .TW(TW)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .en    (run_en),
        .grant (grant),
        .idx   (gidx)
    );

    // whole pipeline advances together; stage 1 samples the multiplier output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_v   <= 1'b0;
            s0_a   <= '0;
            s0_b   <= '0;
            s0_tag <= '0;
            st_v   <= '0;
            ptr    <= '0;
            for (int k = 0; k < NS; k++) begin
                st_p[k]   <= '0;
                st_tag[k] <= '0;
            end
        end else if (adv) begin
            s0_v      <= accept;
            st_p[0]   <= mul_p;
            st_tag[0] <= s0_tag;
            st_v[0]   <= s0_v;
            for (int k = 1; k < NS; k++) begin
                st_p[k]   <= st_p[k-1];
                st_tag[k] <= st_tag[k-1];
                st_v[k]   <= st_v[k-1];
            end
            if (accept) begin
                s0_a   <= req_a[FP_W*gidx +: FP_W];
                s0_b   <= req_b[FP_W*gidx +: FP_W];
                s0_tag <= gidx;
                ptr    <= (gidx == TW'(NREQ - 1)) ? '0 : gidx + TW'(1);
            end
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nx;
    end

    // RUN enters DRAIN on request; DRAIN leaves once empty and released
    always_comb begin
        state_nx = state;
        if (state == RUN && drain_req)                 state_nx = DRAIN;
        else if (state == DRAIN && !any_v && !drain_req) state_nx = RUN;
    end

`ifdef FPMUL_ARB_STATS_EN
    logic [15:0] cnt [NREQ];

    // saturating per-requester accept counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (grant[i] && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        assign stat_grants[16*g +: 16] = cnt[g];
    end
`else
    assign stat_grants = '0;
`endif
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb_fp_mul_arbiter: randomized and directed checks of fp_mul_arbiter against a queue-based reference model
module tb_fp_mul_arbiter;
    localparam int NREQ = 4;
    localparam int LAT  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_a = '0;
    logic [NREQ*32-1:0]   req_b = '0;
    logic [NREQ-1:0]      rsp_valid;
    logic [31:0]          rsp_data;
    logic [NREQ-1:0]      rsp_ready = '1;
    logic                 drain_req = 1'b0;
    logic                 idle;
    logic [31:0]          mul_a, mul_b, mul_p;
    logic [NREQ*16-1:0]   stat_grants;

    typedef struct packed {
        logic        v;
        logic [1:0]  tag;
        logic [31:0] p;
    } ent_t;

    ent_t        sl [LAT];
    int          m_ptr, m_g;
    bit          m_drain, m_adv, m_any;
    int unsigned m_cnt [NREQ];
    int          checks = 0;
    int          errors = 0;

    fp_mul_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_ready   (rsp_ready),
        .drain_req   (drain_req),
        .idle        (idle),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_p       (mul_p),
        .stat_grants (stat_grants)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        logic [7:0]  e;
        m = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
        e = a[30:23] + b[30:23] - 8'd127;
        if (m[47]) begin
            e = e + 8'd1;
            return {a[31] ^ b[31], e, m[46:24]};
        end
        return {a[31] ^ b[31], e, m[45:23]};
    endfunction

    assign mul_p = fp_model(mul_a, mul_b);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < LAT; k++) sl[k] = '0;
        m_ptr   = 0;
        m_drain = 0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    endtask

    task automatic model_check();
        ent_t            o;
        logic [NREQ-1:0] er;
        logic [15:0]     es;
        o     = sl[LAT-1];
        m_adv = !o.v || rsp_ready[o.tag];
        m_any = 0;
        for (int k = 0; k < LAT; k++) m_any |= sl[k].v;
        m_g = -1;
        if (m_adv && !m_drain && !drain_req)
            for (int k = 0; k < NREQ; k++)
                if (m_g < 0 && req_valid[(m_ptr + k) % NREQ]) m_g = (m_ptr + k) % NREQ;
        er = (m_g >= 0) ? NREQ'(1) << m_g : '0;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("rsp_valid", 64'(rsp_valid), o.v ? 64'(NREQ'(1) << o.tag) : 64'd0);
        if (o.v) chk("rsp_data", 64'(rsp_data), 64'(o.p));
        chk("idle", 64'(idle), 64'(!m_any));
        for (int i = 0; i < NREQ; i++) begin
`ifdef FPMUL_ARB_STATS_EN
            es = 16'(m_cnt[i]);
`else
            es = 16'd0;
`endif
            chk($sformatf("stat%0d", i), 64'(stat_grants[16*i +: 16]), 64'(es));
        end
    endtask

    task automatic model_update();
        if (m_adv) begin
            for (int k = LAT - 1; k > 0; k--) sl[k] = sl[k-1];
            sl[0].v = (m_g >= 0);
            if (m_g >= 0) begin
                sl[0].tag = 2'(m_g);
                sl[0].p   = fp_model(req_a[32*m_g +: 32], req_b[32*m_g +: 32]);
                m_ptr     = (m_g + 1) % NREQ;
                if (m_cnt[m_g] < 65535) m_cnt[m_g]++;
            end
        end
        if (!m_drain && drain_req)                  m_drain = 1;
        else if (m_drain && !m_any && !drain_req)   m_drain = 0;
    endtask

    task automatic cycle();
        #4;
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = {$urandom_range(0, 1) == 1, 8'($urandom_range(100, 150)), 23'($urandom)};
            req_b[32*i +: 32] = {$urandom_range(0, 1) == 1, 8'($urandom_range(100, 150)), 23'($urandom)};
        end
    endtask

    initial begin
        logic [31:0] held;
        bit          found;
        model_reset();
        #2;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_mul_a", 64'(mul_a), 64'd0);
        chk("rst_mul_b", 64'(mul_b), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        req_valid        = 4'b0001;
        req_a[31:0]      = 32'h40000000;
        req_b[31:0]      = 32'h40400000;
        cycle();
        req_valid = '0;
        cycle();
        #3;
        chk("single_valid", 64'(rsp_valid), 64'h1);
        chk("single_data", 64'(rsp_data), 64'h40C00000);

        req_valid = '1;
        for (int n = 0; n < 16; n++) begin
            rand_ops();
            cycle();
        end

        found = 0;
        for (int n = 0; n < 16 && !found; n++) begin
            if (sl[LAT-1].v && sl[LAT-1].tag == 2'd1) found = 1;
            else begin
                rand_ops();
                cycle();
            end
        end
        chk("stall_find", 64'(found), 64'd1);
        held      = sl[LAT-1].p;
        rsp_ready = 4'b1101;
        for (int n = 0; n < 5; n++) begin
            chk("stall_hold", 64'(rsp_data), 64'(held));
            rand_ops();
            cycle();
        end
        rsp_ready = '1;
        for (int n = 0; n < 10; n++) begin
            rand_ops();
            cycle();
        end

        drain_req = 1'b1;
        cycle();
        cycle();
        #3;
        chk("drain_idle", 64'(idle), 64'd1);
        chk("drain_ready", 64'(req_ready), 64'd0);
        for (int n = 0; n < 3; n++) cycle();
        drain_req = 1'b0;
        for (int n = 0; n < 8; n++) begin
            rand_ops();
            cycle();
        end

        for (int n = 0; n < 600; n++) begin
            req_valid = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '1;
            drain_req = ($urandom_range(0, 19) == 0);
            rand_ops();
            cycle();
        end
        drain_req = 1'b0;
        rsp_ready = '1;

        req_valid = '1;
        for (int n = 0; n < 3; n++) begin
            rand_ops();
            cycle();
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_idle", 64'(idle), 64'd1);
        model_reset();
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        req_valid = '1;
        for (int n = 0; n < 8; n++) begin
            rand_ops();
            cycle();
        end

`ifdef FPMUL_ARB_STATS_EN
        req_valid = 4'b0100;
        for (int n = 0; n < 70000; n++) cycle();
        chk("stat2_sat", 64'(stat_grants[47:32]), 64'hFFFF);
`endif
        req_valid = '0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
